// File: rtl/toggle_gen.sv
// Source-side half of a toggle CDC pulse synchronizer: each sampled pulse bit
// inverts its registered toggle level, which the destination side edge-detects.
module toggle_gen #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pulse,
    output logic [WIDTH-1:0] toggle
);

    logic [WIDTH-1:0] q;

    // toggle comes straight from the flop so the crossing signal never glitches
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= q ^ pulse;
        end
    end

    assign toggle = q;

endmodule

// File: tb/tb_toggle_gen.sv
// Scoreboard bench for toggle_gen: stimulus pushes the expected toggle level,
// derived from per-channel pulse counts, and a monitor pops and compares.
module tb_toggle_gen;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic [W-1:0] pulse;
    logic [W-1:0] toggle;

    toggle_gen #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .pulse  (pulse),
        .toggle (toggle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] sb_q[$];
    int unsigned  pulse_cnt [W];
    int           edge_cnt = 0;
    bit           watch_edges = 1'b0;

    // Reference: each channel's level is the parity of pulses accepted since reset
    task automatic step(input logic rst_v, input logic [W-1:0] pulse_v);
        logic [W-1:0] exp_v;
        @(negedge clk);
        rst   = rst_v;
        pulse = pulse_v;
        for (int i = 0; i < W; i++) begin
            if (rst_v) pulse_cnt[i] = 0;
            else if (pulse_v[i]) pulse_cnt[i] = pulse_cnt[i] + 1;
            exp_v[i] = (pulse_cnt[i] % 2) == 1;
        end
        sb_q.push_back(exp_v);
    endtask

    always @(posedge clk) begin
        logic [W-1:0] exp_v;
        #1;
        if (sb_q.size() > 0) begin
            exp_v = sb_q.pop_front();
            checks++;
            if (toggle !== exp_v) begin
                errors++;
                $display("FAIL toggle_level t=%0t got=%b expected=%b", $time, toggle, exp_v);
            end
        end
    end

    always @(toggle) begin
        if (watch_edges) edge_cnt++;
    end

    initial begin
        int budget;
        rst   = 1'b1;
        pulse = '0;

        // reset, then idle
        step(1'b1, '0);
        step(1'b1, '0);
        repeat (5) step(1'b0, '0);

        // three isolated single pulses on channel 0
        repeat (3) begin
            step(1'b0, 4'b0001);
            repeat (5) step(1'b0, '0);
        end

        // back to 0 on ch0, then a held pulse for 4 cycles
        step(1'b0, 4'b0001);
        repeat (4) step(1'b0, 4'b0001);
        step(1'b0, '0);

        // reset priority over a coincident pulse
        step(1'b0, 4'b0001);
        step(1'b1, 4'b1111);
        step(1'b0, 4'b0001);
        step(1'b0, '0);

        // independent channels
        step(1'b1, '0);
        step(1'b0, 4'b0101);
        step(1'b0, 4'b0011);
        step(1'b0, '0);

        // idle stability: no transitions at all over 50 cycles
        step(1'b0, 4'b1010);
        @(posedge clk);
        #2;
        edge_cnt    = 0;
        watch_edges = 1'b1;
        repeat (50) step(1'b0, '0);
        @(posedge clk);
        #2;
        watch_edges = 1'b0;
        checks++;
        if (edge_cnt != 0) begin
            errors++;
            $display("FAIL idle_transitions got=%0d expected=0", edge_cnt);
        end

        // randomized traffic with occasional resets
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 31) == 0), W'($urandom));
        end
        step(1'b0, '0);

        budget = 20;
        while (sb_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #2;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d pending expected=0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
